lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store control unit between the core's execute stage and the word-only data memory (DataMem). It turns RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW requests into aligned 32-bit word accesses. Loads are lane-extracted and sign- or zero-extended. Sub-word stores are done as read-modify-write. Misaligned and illegal requests are flagged without touching memory.

## Interface
- ADDR_W, 32, request/memory address width.
- Clk  in  1  clock; all state changes on posedge.
- Rst_n  in  1  reset, asynchronous, active-low.
- Req_valid  in  1  core request present.
- Req_ready  out  1  high only in IDLE; a request is accepted on a posedge with Req_valid && Req_ready.
- Req_we  in  1  1 = store, 0 = load.
- Req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- Req_addr  in  ADDR_W  byte address.
- Req_wdata  in  32  store data, right-aligned.
- Rsp_valid  out  1  one-cycle completion pulse; no backpressure.
- Rsp_rdata  out  32  load result; held until the next response.
- Rsp_err  out  1  qualifies Rsp_valid: misaligned or illegal request.
- Mem_addr  out  ADDR_W  word-aligned address: {addr[ADDR_W-1:2],2'b00}.
- Mem_rd_en  out  1  read strobe.
- Mem_rdata  in  32  combinational read data for the current Mem_addr.
- Mem_wr_en  out  1  write strobe; memory writes on the posedge ending the cycle.
- Mem_wdata  out  32  full word to write.

## Operation
- Request fields are captured into registers on acceptance. Inputs are ignored outside IDLE.
- Legality check on the captured fields:
  - Illegal funct3 (011, 110, 111) is an error.
  - Store with funct3 100/101 is an error.
  - H/HU with addr[0]=1 is misaligned.
  - W with addr[1:0]≠0 is misaligned.
- FSM states are IDLE, READ, WRITE, RESP.
- IDLE to RESP: the request is an error.
- IDLE to READ: a load, or an SB/SH.
- IDLE to WRITE: an SW.
- READ to RESP for a load. READ to WRITE for SB/SH.
- WRITE to RESP.
- RESP to IDLE, unconditionally.
- READ behaviour:
  - Mem_rd_en=1; Mem_rdata is registered at the end of the cycle.
  - Loads: select byte lane addr[1:0] or half lane addr[1].
  - B/H are sign-extended; BU/HU are zero-extended; W is passed through.
- WRITE behaviour:
  - Mem_wr_en=1.
  - SW: Mem_wdata = wdata.
  - SB: read word with byte lane addr[1:0] replaced by wdata[7:0].
  - SH: half lane addr[1] replaced by wdata[15:0].
- RESP behaviour:
  - Rsp_valid=1.
  - Rsp_rdata is the load result.
  - For stores Rsp_rdata is unchanged.
  - For errors Rsp_rdata=0 and Rsp_err=1.
- Error requests never assert Mem_rd_en or Mem_wr_en.
- Mem_addr holds the captured aligned address in READ/WRITE. It is don't-care in other states but never X.
- Mem_rd_en and Mem_wr_en are never high in the same cycle.

## Timing
- Reset values:
  - State IDLE; Req_ready=1.
  - Rsp_valid=0, Rsp_err=0, Rsp_rdata=0.
  - Mem_rd_en=0, Mem_wr_en=0, Mem_addr=0, Mem_wdata=0.
- Latency, counted from accept edge E (cycle N = IDLE with Req_valid):
  - Error: Rsp_valid in cycle N+1.
  - Load and SW: Rsp_valid in cycle N+2.
  - SB/SH: Rsp_valid in cycle N+3.
- Req_ready returns to 1 in the cycle after RESP.
- Maximum throughput: one SW or load per 3 cycles; one SB/SH per 4 cycles.
- Req_valid held high across a busy period: exactly one acceptance per IDLE visit. No request is lost or duplicated.
- Reset asserted mid-operation:
  - Immediate abort; outputs go to reset values asynchronously.
  - A write not yet in WRITE is never issued.
  - Rsp_valid is not produced for the aborted request.
- Mem_wdata is stable for the whole WRITE cycle; merge data comes from the registered read word, not live Mem_rdata.

## Test plan
- Preload word 0x10 = 0x8899AABB, then load LB 0x13 → Rsp_rdata 0xFFFFFF88 at N+2. LBU 0x13 → 0x00000088. LH 0x10 → 0xFFFFAABB. LW 0x10 → 0x8899AABB. Rsp_err=0 throughout.
- SH wdata 0x00001234 to 0x12 → READ at N+1, WRITE at N+2 with Mem_addr 0x10 and Mem_wdata 0x1234AABB, Rsp_valid at N+3. A following LW 0x10 returns 0x1234AABB.
- SB 0x5A to 0x11 on 0x8899AABB → Mem_wdata 0x88995ABB. SW 0xDEADBEEF to 0x14 → single WRITE at N+1, no Mem_rd_en, Rsp_valid at N+2.
- SW to 0x16, LH from 0x11, funct3 011 load, and SB with funct3 100 → each gives Rsp_valid=1, Rsp_err=1, Rsp_rdata=0 at N+1. Zero Mem_rd_en/Mem_wr_en pulses; memory unchanged.
- Req_valid held high for 3 SW requests back-to-back → acceptances at cycles 0, 3, 6. Exactly 3 WRITE pulses and 3 Rsp_valid pulses.
- Rst_n pulled low during READ of an SB to 0x10 → all outputs 0 immediately and no Mem_wr_en ever. Word 0x10 is still 0x8899AABB. Req_ready=1 after Rst_n rises, and the next LW completes normally.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store control unit: turns byte/half/word requests into aligned word
// accesses on a word-only memory, with read-modify-write for sub-word stores.
module lsu_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_en_o,
  input  logic [31:0]       mem_rdata_i,
  output logic              mem_wr_en_o,
  output logic [31:0]       mem_wdata_o
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

  state_e            state_q, state_d;
  logic              we_q, err_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, rword_q, rsp_rdata_q;
  logic              accept, req_bad;

  function automatic logic is_illegal(input logic we, input logic [2:0] f3,
                                      input logic [1:0] lo);
    logic bad;
    case (f3)
      3'b000:  bad = 1'b0;
      3'b001:  bad = lo[0];
      3'b010:  bad = (lo != 2'b00);
      3'b100:  bad = we;
      3'b101:  bad = we | lo[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [2:0] f3,
                                               input logic [1:0] lo);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [31:0] wd,
                                              input logic [2:0] f3,
                                              input logic [1:0] lo);
    logic [31:0] r;
    r = word;
    case (f3[1:0])
      2'b00:   r[{lo, 3'b000} +: 8]    = wd[7:0];
      2'b01:   r[{lo[1], 4'b0000} +: 16] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  assign accept  = req_valid_i && (state_q == IDLE);
  assign req_bad = is_illegal(req_we_i, req_funct3_i, req_addr_i[1:0]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (req_bad)                               state_d = RESP;
          else if (req_we_i && req_funct3_i == 3'b010) state_d = WRITE;
          else                                       state_d = READ;
        end
      end
      READ:    state_d = we_q ? WRITE : RESP;
      WRITE:   state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = (state_q == IDLE);
    mem_rd_en_o = (state_q == READ);
    mem_wr_en_o = (state_q == WRITE);
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (state_q == READ || state_q == WRITE)
      mem_addr_o = {addr_q[ADDR_W-1:2], 2'b00};
    // Merge uses the word registered in READ so the write data cannot glitch.
    if (state_q == WRITE)
      mem_wdata_o = store_merge(rword_q, wdata_q, f3_q, addr_q[1:0]);
    rsp_valid_o = (state_q == RESP);
    rsp_err_o   = (state_q == RESP) && err_q;
    rsp_rdata_o = rsp_rdata_q;
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      we_q    <= req_we_i;
      f3_q    <= req_funct3_i;
      addr_q  <= req_addr_i;
      wdata_q <= req_wdata_i;
      err_q   <= req_bad;
    end
    if (state_q == READ) rword_q <= mem_rdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      rsp_rdata_q <= '0;
    else if (accept && req_bad)
      rsp_rdata_q <= '0;
    else if (state_q == READ && !we_q)
      rsp_rdata_q <= load_extract(mem_rdata_i, f3_q, addr_q[1:0]);
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: byte-array reference model, word memory
// model, directed cases followed by randomized traffic.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_f3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_addr;
  logic        mem_rd_en, mem_wr_en;
  logic [31:0] mem_rdata, mem_wdata;

  lsu_ctrl #(.ADDR_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_we_i(req_we), .req_funct3_i(req_f3),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .mem_addr_o(mem_addr), .mem_rd_en_o(mem_rd_en),
    .mem_rdata_i(mem_rdata), .mem_wr_en_o(mem_wr_en), .mem_wdata_o(mem_wdata)
  );

  always #5 clk = ~clk;

  // Word memory (16 words, addresses 0x00..0x3F) with a poke port for preload.
  logic [31:0] mem [16];
  logic        poke_en = 1'b0;
  logic [3:0]  poke_idx = 4'd0;
  logic [31:0] poke_val = 32'd0;
  assign mem_rdata = mem[mem_addr[5:2]];
  always @(posedge clk) begin
    if (mem_wr_en)    mem[mem_addr[5:2]] <= mem_wdata;
    else if (poke_en) mem[poke_idx] <= poke_val;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0, wr_cnt = 0, exp_rd = 0, exp_wr = 0;

  logic [7:0]  refb [64];
  logic [31:0] last_rdata = 32'd0;

  typedef struct { logic err; logic [31:0] rdata; int acc; int lat; } rsp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  rsp_t rq[$];
  wr_t  wq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_word(input int base);
    return {refb[base+3], refb[base+2], refb[base+1], refb[base]};
  endfunction

  task automatic poke_word(input int idx, input logic [31:0] val);
    @(negedge clk);
    poke_en = 1'b1; poke_idx = 4'(idx); poke_val = val;
    for (int i = 0; i < 4; i++) refb[idx*4+i] = val[8*i +: 8];
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  // Reference: sizes 1/2/4 bytes, little-endian byte array, in-order completion.
  task automatic model(input logic we, input logic [2:0] f3, input int a,
                       input logic [31:0] wd, input int acc);
    int size;
    logic uns, err;
    logic [31:0] v;
    rsp_t r;
    wr_t w;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    uns  = f3[2];
    err  = (f3 == 3'd3) || (f3 >= 3'd6) || (we && uns) || ((a % size) != 0);
    r.acc = acc;
    if (err) begin
      r.err = 1'b1; r.rdata = 32'd0; r.lat = 1;
      last_rdata = 32'd0;
    end else if (!we) begin
      v = 32'd0;
      for (int i = 0; i < size; i++) v = v | (32'(refb[a+i]) << (8*i));
      if (!uns && size < 4 && v[8*size-1])
        v = v | ((size == 1) ? 32'hFFFF_FF00 : 32'hFFFF_0000);
      last_rdata = v;
      r.err = 1'b0; r.rdata = v; r.lat = 2;
      exp_rd++;
    end else begin
      for (int i = 0; i < size; i++) refb[a+i] = wd[8*i +: 8];
      w.addr = 32'(a & ~3);
      w.data = ref_word(a & ~3);
      wq.push_back(w);
      r.err = 1'b0; r.rdata = last_rdata; r.lat = (size == 4) ? 2 : 3;
      exp_wr++;
      if (size < 4) exp_rd++;
    end
    rq.push_back(r);
  endtask

  int last_acc;

  task automatic issue(input logic we, input logic [2:0] f3, input int a,
                       input logic [31:0] wd, input bit hold);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_f3 = f3; req_addr = 32'(a); req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
    end else begin
      last_acc = cyc;
      model(we, f3, a, wd, cyc);
      @(posedge clk);
      #1;
      if (!hold) req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rq.size() != 0 || wq.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_rsp_q", 32'(rq.size()), 32'd0);
    chk("drain_wr_q", 32'(wq.size()), 32'd0);
    @(negedge clk);
  endtask

  // Monitor: responses, write pulses, strobe exclusivity.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_rd_en) rd_cnt++;
      if (mem_wr_en) wr_cnt++;
      if (mem_rd_en && mem_wr_en) chk("rd_wr_exclusive", 32'd1, 32'd0);
      if (rsp_valid) begin
        if (rq.size() == 0) chk("spurious_rsp", 32'd1, 32'd0);
        else begin
          rsp_t e;
          e = rq.pop_front();
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
        end
      end
      if (mem_wr_en) begin
        if (wq.size() == 0) chk("spurious_write", mem_addr, 32'hFFFF_FFFF);
        else begin
          wr_t w;
          w = wq.pop_front();
          chk("wr_addr", mem_addr, w.addr);
          chk("wr_data", mem_wdata, w.data);
        end
      end
    end
  end

  int accs[3];

  initial begin
    for (int i = 0; i < 16; i++) poke_word(i, $urandom);
    poke_word(4, 32'h8899_AABB);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_mem_strobes", {30'd0, mem_rd_en, mem_wr_en}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    #1 rst_n = 1'b1;

    issue(1'b0, 3'b000, 'h13, 32'd0, 1'b0);
    issue(1'b0, 3'b100, 'h13, 32'd0, 1'b0);
    issue(1'b0, 3'b001, 'h10, 32'd0, 1'b0);
    issue(1'b0, 3'b010, 'h10, 32'd0, 1'b0);
    issue(1'b1, 3'b001, 'h12, 32'h0000_1234, 1'b0);
    issue(1'b0, 3'b010, 'h10, 32'd0, 1'b0);
    drain();
    chk("sh_word_0x10", mem[4], 32'h1234_AABB);

    poke_word(4, 32'h8899_AABB);
    issue(1'b1, 3'b000, 'h11, 32'h0000_005A, 1'b0);
    issue(1'b1, 3'b010, 'h14, 32'hDEAD_BEEF, 1'b0);
    drain();
    chk("sb_word_0x10", mem[4], 32'h8899_5ABB);
    chk("sw_word_0x14", mem[5], 32'hDEAD_BEEF);

    issue(1'b1, 3'b010, 'h16, 32'h1111_1111, 1'b0);
    issue(1'b0, 3'b001, 'h11, 32'd0, 1'b0);
    issue(1'b0, 3'b011, 'h20, 32'd0, 1'b0);
    issue(1'b1, 3'b100, 'h10, 32'h2222_2222, 1'b0);
    drain();

    for (int k = 0; k < 3; k++) begin
      issue(1'b1, 3'b010, 'h20 + 4*k, $urandom, 1'b1);
      accs[k] = last_acc;
    end
    @(negedge clk);
    req_valid = 1'b0;
    drain();
    chk("b2b_gap1", 32'(accs[1] - accs[0]), 32'd3);
    chk("b2b_gap2", 32'(accs[2] - accs[0]), 32'd6);

    // Abort an SB to 0x10 while it is reading.
    poke_word(4, 32'h8899_AABB);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_f3 = 3'b000; req_addr = 32'h10;
    req_wdata = 32'h0000_0077;
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("abort_in_read", 32'(mem_rd_en), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_strobes", {30'd0, mem_rd_en, mem_wr_en}, 32'd0);
    chk("abort_rsp", {30'd0, rsp_valid, rsp_err}, 32'd0);
    chk("abort_addr", mem_addr, 32'd0);
    chk("abort_wdata", mem_wdata, 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd1);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    last_rdata = 32'd0;
    @(negedge clk);
    chk("post_abort_ready", 32'(req_ready), 32'd1);
    chk("post_abort_word", mem[4], 32'h8899_AABB);
    issue(1'b0, 3'b010, 'h10, 32'd0, 1'b0);
    drain();

    for (int k = 0; k < 120; k++) begin
      logic we;
      logic [2:0] f3;
      bit hold;
      we   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      hold = ($urandom_range(0, 3) == 0);
      issue(we, f3, $urandom_range(0, 63), $urandom, hold);
      if (!hold && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    @(negedge clk);
    req_valid = 1'b0;
    drain();

    chk("total_rd_pulses", 32'(rd_cnt), 32'(exp_rd));
    chk("total_wr_pulses", 32'(wr_cnt), 32'(exp_wr));
    for (int i = 0; i < 16; i++) chk($sformatf("final_word_%0d", i), mem[i], ref_word(4*i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
